// File: rtl/data_bus_pkg.sv
// rtl/data_bus_pkg.sv - shared state encoding and index-width helper for the data bus dispatcher
package data_bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Index registers are never narrower than one bit, even for a single unit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/next_unit_finder.sv
// rtl/next_unit_finder.sv - priority encoder returning the lowest enabled unit index above a base
//
// Ports:
//   mask_i      per-unit enable
//   base_i      search starts above this index (at it when inclusive_i is 1)
//   inclusive_i 1: base_i itself is a candidate (first-unit search); 0: strictly above (advance)
//   idx_o       lowest enabled candidate index, 0 when none
//   none_o      no enabled candidate remains
module next_unit_finder
    import data_bus_pkg::*;
#(
    parameter int UNIT_NUM = 3,
    parameter int IDX_W    = idx_width(UNIT_NUM)
) (
    input  logic [UNIT_NUM-1:0] mask_i,
    input  logic [IDX_W-1:0]    base_i,
    input  logic                inclusive_i,
    output logic [IDX_W-1:0]    idx_o,
    output logic                none_o
);

    // Scanning downward lets the lowest matching index win the final assignment.
    always_comb begin
        idx_o  = '0;
        none_o = 1'b1;
        for (int j = UNIT_NUM - 1; j >= 0; j--) begin
            if (mask_i[j] && ((j > int'(base_i)) || (inclusive_i && (j == int'(base_i))))) begin
                idx_o  = IDX_W'(j);
                none_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/data_bus_dispatcher.sv
// rtl/data_bus_dispatcher.sv - splits a wide word into units emitted one per handshake, lowest unit first
//
// Optional feature: DISPATCHER_SKIP_MASK_EN adds in_mask_i; units whose mask bit is 0 are skipped.
//
// Ports:
//   sys_clk, rstn           clock, asynchronous active-low reset
//   port_in_i/in_valid_i    wide word input, accepted when in_ready_o is 1
//   in_ready_o              registered; 1 only while idle
//   in_mask_i               per-unit emit enable (DISPATCHER_SKIP_MASK_EN only)
//   unit_o/unit_sel_o       current unit data and its one-hot position
//   unit_valid_o            unit outputs valid
//   unit_ready_i            downstream accepts the current unit
//   unit_last_o             current unit is the final emitted unit of the word
//   word_done_o             one-cycle pulse after the final unit handshake (or an empty-mask accept)
module data_bus_dispatcher
    import data_bus_pkg::*;
#(
    parameter int UNIT_NUM   = 3,
    parameter int UNIT_WIDTH = 4
) (
    input  logic                           sys_clk,
    input  logic                           rstn,
    input  logic [UNIT_NUM*UNIT_WIDTH-1:0] port_in_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
`ifdef DISPATCHER_SKIP_MASK_EN
    input  logic [UNIT_NUM-1:0]            in_mask_i,
`endif
    output logic [UNIT_WIDTH-1:0]          unit_o,
    output logic [UNIT_NUM-1:0]            unit_sel_o,
    output logic                           unit_valid_o,
    input  logic                           unit_ready_i,
    output logic                           unit_last_o,
    output logic                           word_done_o
);

    localparam int IDX_W = idx_width(UNIT_NUM);

    state_e                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [UNIT_NUM*UNIT_WIDTH-1:0] word_q, word_d;
    logic [UNIT_NUM-1:0]            mask_q, mask_d;
    logic                           in_ready_q, in_ready_d;
    logic                           done_q, done_d;

    logic [UNIT_NUM-1:0]            mask_in;
    logic [IDX_W-1:0]               first_idx, adv_idx;
    logic                           first_none, adv_none;

`ifdef DISPATCHER_SKIP_MASK_EN
    assign mask_in = in_mask_i;
`else
    assign mask_in = '1;
`endif

    // First enabled unit of the incoming word, searched from index 0 inclusive.
    next_unit_finder #(
        .UNIT_NUM (UNIT_NUM),
        .IDX_W    (IDX_W)
    ) u_first_finder (
        .mask_i      (mask_in),
        .base_i      ('0),
        .inclusive_i (1'b1),
        .idx_o       (first_idx),
        .none_o      (first_none)
    );

    // Next enabled unit after the current one; none_o marks the current unit as last.
    next_unit_finder #(
        .UNIT_NUM (UNIT_NUM),
        .IDX_W    (IDX_W)
    ) u_adv_finder (
        .mask_i      (mask_q),
        .base_i      (idx_q),
        .inclusive_i (1'b0),
        .idx_o       (adv_idx),
        .none_o      (adv_none)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        mask_d  = mask_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid_i && in_ready_q) begin
                    word_d = port_in_i;
                    mask_d = mask_in;
                    if (first_none) begin
                        // Nothing to emit: the word completes immediately.
                        done_d = 1'b1;
                    end else begin
                        idx_d   = first_idx;
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (unit_ready_i) begin
                    if (adv_none) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = adv_idx;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered copy of "will be idle" so in_ready_o has no input-to-output path
        // and stays low until the first edge after reset release.
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            word_q     <= '0;
            mask_q     <= '0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            mask_q     <= mask_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
        end
    end

    // Unit outputs are decoded from registered state only, so they hold while unit_ready_i is low.
    always_comb begin
        unit_o     = '0;
        unit_sel_o = '0;
        if (state_q == SEND) begin
            for (int j = 0; j < UNIT_NUM; j++) begin
                if (idx_q == IDX_W'(j)) begin
                    unit_o        = word_q[j*UNIT_WIDTH +: UNIT_WIDTH];
                    unit_sel_o[j] = 1'b1;
                end
            end
        end
    end

    assign unit_valid_o = (state_q == SEND);
    assign unit_last_o  = (state_q == SEND) && adv_none;
    assign in_ready_o   = in_ready_q;
    assign word_done_o  = done_q;

endmodule

// File: tb/tb_data_bus_dispatcher.sv
// tb/tb_data_bus_dispatcher.sv - scoreboard bench for data_bus_dispatcher
module tb_data_bus_dispatcher;

    logic        sys_clk = 1'b0;
    logic        rstn = 1'b0;
    logic [11:0] port_in_i = '0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
`ifdef DISPATCHER_SKIP_MASK_EN
    logic [2:0]  in_mask_i = 3'b111;
`endif
    logic [3:0]  unit_o;
    logic [2:0]  unit_sel_o;
    logic        unit_valid_o;
    logic        unit_ready_i = 1'b0;
    logic        unit_last_o;
    logic        word_done_o;

    data_bus_dispatcher #(
        .UNIT_NUM   (3),
        .UNIT_WIDTH (4)
    ) dut (
        .sys_clk      (sys_clk),
        .rstn         (rstn),
        .port_in_i    (port_in_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
`ifdef DISPATCHER_SKIP_MASK_EN
        .in_mask_i    (in_mask_i),
`endif
        .unit_o       (unit_o),
        .unit_sel_o   (unit_sel_o),
        .unit_valid_o (unit_valid_o),
        .unit_ready_i (unit_ready_i),
        .unit_last_o  (unit_last_o),
        .word_done_o  (word_done_o)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic [3:0] d;
        logic [2:0] s;
        logic       l;
    } exp_t;

    exp_t exp_q[$];
    int   done_exp = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [3:0] d, input logic [2:0] s, input logic l);
        exp_t e;
        e.d = d;
        e.s = s;
        e.l = l;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every presented unit against the scoreboard head and pops on handshake.
    always @(negedge sys_clk) begin
        if (rstn) begin
            if (unit_valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_unit actual=%0h sel=%0b required=none", unit_o, unit_sel_o);
                end else begin
                    check("unit_data", unit_o, exp_q[0].d);
                    check("unit_sel", unit_sel_o, exp_q[0].s);
                    check("unit_last", unit_last_o, exp_q[0].l);
                    if (unit_ready_i) void'(exp_q.pop_front());
                end
            end
            if (word_done_o) begin
                check("done_in_ready", in_ready_o, 1);
                checks++;
                if (done_exp == 0) begin
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    done_exp--;
                end
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic accept(input logic [11:0] w, input logic [2:0] m, output int acc_cyc);
        int n;
        n = 0;
        while (!in_ready_o && n < 30) begin
            tick();
            n++;
        end
        if (!in_ready_o) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=0 required=1");
        end
        port_in_i  = w;
`ifdef DISPATCHER_SKIP_MASK_EN
        in_mask_i  = m;
`else
        if (m != 3'b111) $display("note: mask ignored in default build");
`endif
        in_valid_i = 1'b1;
        @(posedge sys_clk);
        acc_cyc = cyc;
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || done_exp != 0) && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || done_exp != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d/%0d required=0/0", exp_q.size(), done_exp);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1;

        // Reset state, with clock edges running during reset.
        #22;
        check("rst_in_ready", in_ready_o, 0);
        check("rst_valid", unit_valid_o, 0);
        check("rst_unit", unit_o, 0);
        check("rst_sel", unit_sel_o, 0);
        check("rst_last", unit_last_o, 0);
        check("rst_done", word_done_o, 0);
        @(negedge sys_clk);
        rstn = 1'b1;
        #1;
        check("rel_in_ready_before_edge", in_ready_o, 0);
        tick();
        check("rel_in_ready_first_edge", in_ready_o, 1);

        // Word 0xCBA with ready high: A, B, C(last), then done.
        unit_ready_i = 1'b1;
        push(4'hA, 3'b001, 1'b0);
        push(4'hB, 3'b010, 1'b0);
        push(4'hC, 3'b100, 1'b1);
        done_exp = 1;
        accept(12'hCBA, 3'b111, c0);
        check("lat_valid_n1", unit_valid_o, 1);
        check("lat_unit_a", unit_o, 4'hA);
        check("lat_in_ready_low", in_ready_o, 0);
        tick();
        check("seq_unit_b", unit_o, 4'hB);
        tick();
        check("seq_unit_c", unit_o, 4'hC);
        check("seq_last_c", unit_last_o, 1);
        tick();
        check("seq_done", word_done_o, 1);
        check("seq_valid_off", unit_valid_o, 0);
        check("seq_idle_unit", unit_o, 0);
        check("seq_idle_sel", unit_sel_o, 0);
        tick();
        check("seq_done_pulse", word_done_o, 0);
        check("seq_in_ready", in_ready_o, 1);
        drain();

        // Back-to-back words: one word per 4 cycles.
        push(4'hA, 3'b001, 1'b0);
        push(4'hB, 3'b010, 1'b0);
        push(4'hC, 3'b100, 1'b1);
        push(4'h3, 3'b001, 1'b0);
        push(4'h2, 3'b010, 1'b0);
        push(4'h1, 3'b100, 1'b1);
        done_exp = 2;
        accept(12'hCBA, 3'b111, c0);
        accept(12'h123, 3'b111, c1);
        check("throughput_cycles", c1 - c0, 4);
        drain();

        // Stall on unit B for 3 cycles.
        push(4'hA, 3'b001, 1'b0);
        push(4'hB, 3'b010, 1'b0);
        push(4'hC, 3'b100, 1'b1);
        done_exp = 1;
        accept(12'hCBA, 3'b111, c0);
        tick();
        unit_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_unit_b", unit_o, 4'hB);
            check("stall_sel_b", unit_sel_o, 3'b010);
            tick();
        end
        unit_ready_i = 1'b1;
        check("stall_still_b", unit_o, 4'hB);
        tick();
        check("stall_then_c", unit_o, 4'hC);
        drain();

        // in_valid held with changing data during SEND must not disturb the word.
        push(4'h1, 3'b001, 1'b0);
        push(4'h2, 3'b010, 1'b0);
        push(4'h3, 3'b100, 1'b1);
        done_exp = 1;
        accept(12'h321, 3'b111, c0);
        in_valid_i = 1'b1;
        port_in_i  = 12'hFED;
        tick();
        port_in_i  = 12'h987;
        tick();
        port_in_i  = 12'h456;
        tick();
        in_valid_i = 1'b0;
        drain();

        // Reset during unit B: outputs clear asynchronously, no done pulse.
        push(4'hA, 3'b001, 1'b0);
        push(4'hB, 3'b010, 1'b0);
        push(4'hC, 3'b100, 1'b1);
        done_exp = 1;
        accept(12'hCBA, 3'b111, c0);
        tick();
        unit_ready_i = 1'b0;
        check("pre_rst_unit_b", unit_o, 4'hB);
        #1;
        rstn = 1'b0;
        #1;
        check("arst_valid", unit_valid_o, 0);
        check("arst_unit", unit_o, 0);
        check("arst_sel", unit_sel_o, 0);
        check("arst_last", unit_last_o, 0);
        check("arst_in_ready", in_ready_o, 0);
        check("arst_done", word_done_o, 0);
        exp_q.delete();
        done_exp = 0;
        tick();
        tick();
        @(negedge sys_clk);
        rstn = 1'b1;
        #1;
        check("rel2_in_ready_before_edge", in_ready_o, 0);
        tick();
        check("rel2_in_ready_first_edge", in_ready_o, 1);
        check("rel2_no_done", word_done_o, 0);
        unit_ready_i = 1'b1;
        push(4'h3, 3'b001, 1'b0);
        push(4'h2, 3'b010, 1'b0);
        push(4'h1, 3'b100, 1'b1);
        done_exp = 1;
        accept(12'h123, 3'b111, c0);
        drain();

`ifdef DISPATCHER_SKIP_MASK_EN
        // Mask 101 skips unit F without a wasted cycle.
        push(4'h3, 3'b001, 1'b0);
        push(4'h5, 3'b100, 1'b1);
        done_exp = 1;
        accept(12'h5F3, 3'b101, c0);
        check("mask_first_3", unit_o, 4'h3);
        tick();
        check("mask_then_5", unit_o, 4'h5);
        check("mask_last_5", unit_last_o, 1);
        drain();

        // Empty mask: nothing emitted, immediate done, stays ready.
        done_exp = 1;
        accept(12'hABC, 3'b000, c0);
        check("empty_valid", unit_valid_o, 0);
        check("empty_done", word_done_o, 1);
        check("empty_in_ready", in_ready_o, 1);
        tick();
        check("empty_done_pulse", word_done_o, 0);
        check("empty_in_ready_hold", in_ready_o, 1);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_bus_dispatcher.md
DATA_BUS_DISPATCHER -- requirements
Module: data_bus_dispatcher

Interface
REQ-001 Parameter UNIT_NUM, default 3, number of units per wide word.
REQ-002 Parameter UNIT_WIDTH, default 4, bits per unit.
REQ-003 sys_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rstn  input  1  reset; asynchronous, active-low.
REQ-005 port_in_i  input  UNIT_NUM*UNIT_WIDTH  wide word; unit i is bits [(i+1)*UNIT_WIDTH-1 : i*UNIT_WIDTH].
REQ-006 in_valid_i  input  1  port_in_i valid.
REQ-007 in_ready_o  output  1  dispatcher can accept a word.
REQ-008 in_mask_i  input  UNIT_NUM  per-unit emit enable; exists only when DISPATCHER_SKIP_MASK_EN is defined.
REQ-009 unit_o  output  UNIT_WIDTH  current unit data.
REQ-010 unit_sel_o  output  UNIT_NUM  one-hot index of the current unit; directly drives a combiner's per-unit load enable when ANDed with the handshake.
REQ-011 unit_valid_o  output  1  unit_o/unit_sel_o valid.
REQ-012 unit_ready_i  input  1  downstream accepts the current unit.
REQ-013 unit_last_o  output  1  current unit is the final emitted unit of the word.
REQ-014 word_done_o  output  1  one-cycle pulse after the final unit handshake.

Function
REQ-015 FSM states: IDLE and SEND; in_ready_o SHALL be 1 exactly in IDLE, registered, with no combinational path from any input.
REQ-016 In IDLE, in_valid_i&in_ready_o at edge N SHALL latch port_in_i and the mask, load the index with the first enabled unit, and enter SEND; unit_valid_o SHALL be 1 from cycle N+1.
REQ-017 In SEND, unit_o SHALL equal the latched unit at the index, unit_sel_o SHALL be 1<<index, and unit_valid_o SHALL be 1.
REQ-018 Units SHALL be emitted in ascending index order, unit 0 first.
REQ-019 unit_valid_o&unit_ready_i SHALL advance the index to the next enabled unit; when unit_last_o is 1, it SHALL return to IDLE and pulse word_done_o in the following cycle.
REQ-020 With unit_ready_i low, unit_o, unit_sel_o, unit_valid_o and unit_last_o SHALL hold stable.
REQ-021 in_valid_i during SEND SHALL be ignored and SHALL not disturb the latched word.
REQ-022 Throughput: one word per (enabled units + 1) cycles with unit_ready_i held high.
REQ-023 The index register SHALL be $clog2(UNIT_NUM) bits wide (minimum 1) and SHALL never exceed UNIT_NUM-1.
REQ-024 Outside SEND, unit_valid_o, unit_sel_o and unit_last_o SHALL be 0 and unit_o SHALL be 0.

Reset
REQ-025 rstn low SHALL force IDLE, index 0, latched word 0, in_ready_o 0, and every other output 0, immediately and regardless of sys_clk.
REQ-026 in_ready_o SHALL rise on the first sys_clk edge after rstn deasserts.
REQ-027 Reset mid-SEND SHALL abandon the word without a word_done_o pulse.

Configuration
REQ-028 Macro DISPATCHER_SKIP_MASK_EN defined: in_mask_i is present, and units with mask bit 0 SHALL be skipped without consuming cycles.
REQ-029 An all-zero mask SHALL be accepted, SHALL emit nothing, SHALL stay in IDLE, and SHALL pulse word_done_o in the next cycle.
REQ-030 Macro undefined: in_mask_i is absent and all UNIT_NUM units SHALL be emitted.

Structure
REQ-031 Shared package data_bus_pkg SHALL hold the state encoding (IDLE=0, SEND=1) and the index-width function.
REQ-032 Sub-module next_unit_finder SHALL hold the combinational priority encoder returning the next enabled index above a given index plus a none-left flag, used for both the first index and advance.

Verification
REQ-033 Defaults, word 0xCBA, unit_ready_i=1: after accept, the following cycles SHALL show unit_o=A/sel 001, B/010, C/100 with last on C, then word_done_o=1, then in_ready_o=1.
REQ-034 Same word, unit_ready_i low for 3 cycles on unit B: unit_o=B and sel=010 SHALL hold all 3 cycles, and C SHALL follow one cycle after ready rises.
REQ-035 With the macro, word 0x5F3 and mask 101: emission SHALL be 3/sel 001 then 5/sel 100 with last; unit F SHALL never appear.
REQ-036 With the macro, mask 000: no unit_valid_o, word_done_o SHALL pulse once, and in_ready_o SHALL stay 1.
REQ-037 rstn low during unit B: all outputs SHALL be 0 asynchronously, with no word_done_o; after release in_ready_o=1 on the first edge, and a new word 0x123 SHALL emit 3, 2, 1 correctly.
REQ-038 in_valid_i held high with changing data during SEND: the emitted units SHALL match only the originally accepted word.
